// File: rtl/mult_16_pkg.sv
// mult16_pkg: shared widths, FSM state type and the Karatsuba recombination step
// for the 16x16 sequential multiplier.
package mult16_pkg;

    localparam int W_IN   = 16;
    localparam int W_HALF = 8;
    localparam int W_SUB  = 9;
    localparam int W_OUT  = 32;

    typedef enum logic [2:0] {IDLE, MUL_LO, MUL_HI, MUL_MID, COMBINE} state_t;

    // z1 = zm - z2 - z0 cannot go negative, so 18 bits suffice; the 34-bit sum always fits in 32.
    function automatic logic [W_OUT-1:0] combine(
        input logic [2*W_HALF-1:0] z0,
        input logic [2*W_HALF-1:0] z2,
        input logic [2*W_SUB-1:0]  zm
    );
        logic [2*W_SUB-1:0] z1;
        logic [33:0]        s;
        z1 = zm - {2'b0, z2} - {2'b0, z0};
        s  = {2'b0, z2, 16'b0} + {8'b0, z1, 8'b0} + {18'b0, z0};
        return s[W_OUT-1:0];
    endfunction

endpackage

// File: rtl/mult_16_mult9.sv
// mult9: combinational unsigned 9x9 -> 18-bit multiplier shared by all partial products.
module mult9
    import mult16_pkg::*;
(
    input  logic [W_SUB-1:0]   a,
    input  logic [W_SUB-1:0]   b,
    output logic [2*W_SUB-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/mult_16.sv
// mult_16: sequential 16x16 unsigned Karatsuba multiplier, one shared 9x9 multiplier,
// start/done handshake with 5-cycle issue interval.
module mult_16
    import mult16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W_IN-1:0]  A,
    input  logic [W_IN-1:0]  B,
    output logic             done,
    output logic [W_OUT-1:0] P
);

    state_t               state;
    logic [W_IN-1:0]      a_r, b_r;
    logic [2*W_HALF-1:0]  z0, z2;
    logic [2*W_SUB-1:0]   zm;
    logic [W_SUB-1:0]     ma, mb;
    logic [2*W_SUB-1:0]   mp;

    // Operand mux: low halves, high halves, then the 9-bit half sums.
    always_comb begin
        ma = state == MUL_LO ? {1'b0, a_r[W_HALF-1:0]} :
             state == MUL_HI ? {1'b0, a_r[W_IN-1:W_HALF]} :
                               {1'b0, a_r[W_HALF-1:0]} + {1'b0, a_r[W_IN-1:W_HALF]};
        mb = state == MUL_LO ? {1'b0, b_r[W_HALF-1:0]} :
             state == MUL_HI ? {1'b0, b_r[W_IN-1:W_HALF]} :
                               {1'b0, b_r[W_HALF-1:0]} + {1'b0, b_r[W_IN-1:W_HALF]};
    end

    mult9 u_mult9 (
        .a(ma),
        .b(mb),
        .p(mp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            z0    <= '0;
            z2    <= '0;
            zm    <= '0;
            P     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_r   <= A;
                    b_r   <= B;
                    state <= MUL_LO;
                end
                MUL_LO: begin
                    z0    <= mp[2*W_HALF-1:0];
                    state <= MUL_HI;
                end
                MUL_HI: begin
                    z2    <= mp[2*W_HALF-1:0];
                    state <= MUL_MID;
                end
                MUL_MID: begin
                    zm    <= mp;
                    state <= COMBINE;
                end
                COMBINE: begin
                    P     <= combine(z0, z2, zm);
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_16.sv
// tb_mult_16: directed and randomized checks of mult_16 against a plain A*B reference.
module tb_mult_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A, B;
    logic        done;
    logic [31:0] P;

    int errors = 0;
    int checks = 0;

    mult_16 dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .A(A),
        .B(B),
        .done(done),
        .P(P)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        return 32'(a) * 32'(b);
    endfunction

    // Pulse start for one edge; returns at the negedge just after the sampling edge.
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start = 1'b1;
        A = a;
        B = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until done is seen, bounded at 20.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (P !== 32'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: P=%h done=%b, want P=0 done=0", P, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [15:0] va [6] = '{16'h0003, 16'h00FF, 16'hFFFF, 16'h1234, 16'hABCD, 16'hFFFF};
        logic [15:0] vb [6] = '{16'h0004, 16'h0002, 16'h0001, 16'h5678, 16'hDCBA, 16'hFFFF};
        logic [31:0] vp [6] = '{32'h0000000C, 32'h000001FE, 32'h0000FFFF, 32'h06260060,
                                32'h9420FEF2, 32'hFFFE0001};
        int n;
        for (int i = 0; i < 6; i++) begin
            launch(va[i], vb[i]);
            wait_done(n);
            checks++;
            if (n !== 4 || P !== vp[i]) begin
                errors++;
                $display("FAIL directed %h*%h: P=%h lat=%0d, want P=%h lat=4", va[i], vb[i], P, n, vp[i]);
            end
        end
    endtask

    task automatic test_handshake;
        logic [31:0] exp_p;
        exp_p = model(16'h1234, 16'h5678);
        launch(16'h1234, 16'h5678);
        // Start pulses and operand changes while busy must be ignored.
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL early_done: done=%b at cycle %0d, want 0", done, k);
            end
            start = 1'b1;
            A = 16'($urandom);
            B = 16'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || P !== exp_p) begin
            errors++;
            $display("FAIL busy_ignore: done=%b P=%h, want done=1 P=%h", done, P, exp_p);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%b one cycle later, want 0", done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (P !== exp_p || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: P=%h done=%b, want P=%h done=0", P, done, exp_p);
        end
        // P must keep the old product while the next operation runs.
        launch(16'hBEEF, 16'h0101);
        repeat (3) begin
            checks++;
            if (P !== exp_p) begin
                errors++;
                $display("FAIL busy_hold: P=%h, want %h", P, exp_p);
            end
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || P !== model(16'hBEEF, 16'h0101)) begin
            errors++;
            $display("FAIL next_op: done=%b P=%h, want done=1 P=%h", done, P, model(16'hBEEF, 16'h0101));
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] qa [4] = '{16'h1111, 16'hFFFF, 16'h8001, 16'h0000};
        logic [15:0] qb [4] = '{16'h2222, 16'hFFFE, 16'h7FFF, 16'h1234};
        logic [31:0] prev;
        int n;
        @(negedge clk);
        start = 1'b1;
        A = qa[0];
        B = qb[0];
        prev = P;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (!done) begin
                    checks++;
                    if (P !== prev) begin
                        errors++;
                        $display("FAIL b2b_hold op%0d: P=%h, want %h", i, P, prev);
                    end
                end
            end while (!done && n < 20);
            checks++;
            if (n !== 5 || P !== model(qa[i], qb[i])) begin
                errors++;
                $display("FAIL b2b op%0d: P=%h interval=%0d, want P=%h interval=5", i, P, n, model(qa[i], qb[i]));
            end
            prev = model(qa[i], qb[i]);
            if (i < 3) begin
                A = qa[i+1];
                B = qb[i+1];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: done=%b after start dropped, want 0", done);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        int n;
        launch(16'h4321, 16'h8765);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (P !== 32'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: P=%h done=%b, want P=0 done=0", P, done);
        end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0 || P !== 32'h0) begin
            errors++;
            $display("FAIL abort: done pulses=%0d P=%h, want 0 pulses P=0", seen, P);
        end
        launch(16'h4321, 16'h8765);
        wait_done(n);
        checks++;
        if (n !== 4 || P !== model(16'h4321, 16'h8765)) begin
            errors++;
            $display("FAIL post_reset: P=%h lat=%0d, want P=%h lat=4", P, n, model(16'h4321, 16'h8765));
        end
    endtask

    task automatic test_random;
        logic [15:0] a, b;
        int n;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 50 == 0) a = '0;
            if (i % 50 == 25) b = '0;
            if (i % 97 == 3) a = 16'hFFFF;
            launch(a, b);
            wait_done(n);
            checks++;
            if (n !== 4 || P !== model(a, b)) begin
                errors++;
                $display("FAIL random %h*%h: P=%h lat=%0d, want P=%h lat=4", a, b, P, n, model(a, b));
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_handshake;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
